// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver: baud divisors for a 12 MHz clock
// and the receiver FSM state encoding.
package uart_rx_pkg;

    // clk cycles per bit at 12 MHz
    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B600    = 20000;
    localparam int B300    = 40000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/baudgen_rx.sv
// Receive-side baud tick generator: first tick half a bit period after enable,
// then one tick per bit period, so every tick lands in the centre of a bit.
module baudgen_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUDRATE = B115200
) (
    input  logic clk,
    input  logic rstn,
    input  logic clk_ena,
    output logic clk_out
);

    localparam int CW = $clog2(BAUDRATE);
    localparam logic [CW-1:0] LAST = CW'(BAUDRATE - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUDRATE / 2 - 1);

    logic [CW-1:0] cnt;

    // Free-running modulo-BAUDRATE count; the tick is taken mid-count so the
    // first one arrives after BAUDRATE/2 cycles.
    always_ff @(posedge clk) begin
        if (!rstn || !clk_ena) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign clk_out = clk_ena && (cnt == HALF);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Define UART_RX_FERR_EN to check the stop bit
// and expose a framing-error strobe on ferr.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUDRATE = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       busy
`ifdef UART_RX_FERR_EN
    ,
    output logic       ferr
`endif
);

    state_t     state, state_nxt;
    logic       rx_meta, rx_s, rx_prev;
    logic [7:0] shreg, shreg_nxt;
    logic [2:0] bcnt, bcnt_nxt;
    logic       rcv_nxt;
    logic       tick;
`ifdef UART_RX_FERR_EN
    logic       ferr_nxt;
`endif

    // Synchroniser and edge history idle high so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign busy = (state != IDLE);

    baudgen_rx #(
        .BAUDRATE(BAUDRATE)
    ) u_baudgen (
        .clk    (clk),
        .rstn   (rstn),
        .clk_ena(busy),
        .clk_out(tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            bcnt  <= '0;
            data  <= 8'h00;
            rcv   <= 1'b0;
`ifdef UART_RX_FERR_EN
            ferr  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            rcv   <= rcv_nxt;
            if (rcv_nxt) begin
                data <= shreg;
            end
`ifdef UART_RX_FERR_EN
            ferr  <= ferr_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        shreg_nxt = shreg;
        rcv_nxt   = 1'b0;
`ifdef UART_RX_FERR_EN
        ferr_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_nxt = DATA;
                        bcnt_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                // Shifting in at the MSB leaves bit 0 at the LSB after eight ticks.
                if (tick) begin
                    shreg_nxt = {rx_s, shreg[7:1]};
                    bcnt_nxt  = bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be caught.
                if (tick) begin
                    state_nxt = IDLE;
`ifdef UART_RX_FERR_EN
                    if (rx_s) begin
                        rcv_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
`else
                    rcv_nxt = 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed vector table, reset-in-frame sequence and
// randomized line traffic compared against a frame-level reference model.
module tb_uart_rx;

    localparam int B   = 104;
    localparam int H   = B / 2;
    localparam int LAT = H + 9 * B + 1;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       rcv;
    logic       busy;
`ifdef UART_RX_FERR_EN
    logic       ferr;
`endif

    uart_rx #(
        .BAUDRATE(B)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .rx  (rx),
        .data(data),
        .rcv (rcv),
        .busy(busy)
`ifdef UART_RX_FERR_EN
        ,
        .ferr(ferr)
`endif
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    logic       wave[$];
    logic       busy_log[$];
    int         rcv_idx[$];
    logic [7:0] rcv_dat[$];
    int         ferr_idx[$];
    int         exp_idx[$];
    logic [7:0] exp_dat[$];
    int         exp_ferr[$];

    typedef struct {
        int         glitch;
        int         nfr;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       stop0;
        int         exp_n;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic add_level(input logic v, input int n);
        repeat (n) wave.push_back(v);
    endtask

    task automatic add_frame(input logic [7:0] b, input logic stop);
        add_level(1'b0, B);
        for (int k = 0; k < 8; k++) add_level(b[k], B);
        add_level(stop, B);
    endtask

    // Drives one wave level per cycle on the falling edge, logging outputs first.
    task automatic play(input int rst_at);
        busy_log.delete();
        rcv_idx.delete();
        rcv_dat.delete();
        ferr_idx.delete();
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            busy_log.push_back(busy);
            if (rcv) begin
                rcv_idx.push_back(i);
                rcv_dat.push_back(data);
            end
`ifdef UART_RX_FERR_EN
            if (ferr) ferr_idx.push_back(i);
`endif
            rx   = wave[i];
            rstn = (i == rst_at) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        rx   = 1'b1;
        rstn = 1'b1;
    endtask

    // Frame-level reference: find start edges while idle, sample each bit centre.
    task automatic model();
        int         idle_from;
        int         s;
        logic       prev;
        logic [7:0] b;
        exp_idx.delete();
        exp_dat.delete();
        exp_ferr.delete();
        idle_from = 0;
        for (int i = 0; i < wave.size(); i++) begin
            prev = (i == 0) ? 1'b1 : wave[i-1];
            if (i >= idle_from && prev && !wave[i]) begin
                s = i + H;
                if (s + 9 * B >= wave.size()) break;
                if (wave[s]) begin
                    idle_from = s + 1;
                end else begin
                    for (int k = 0; k < 8; k++) b[k] = wave[s + (k + 1) * B];
`ifdef UART_RX_FERR_EN
                    if (wave[s + 9 * B]) begin
                        exp_idx.push_back(i + 2 + LAT);
                        exp_dat.push_back(b);
                    end else begin
                        exp_ferr.push_back(i + 2 + LAT);
                    end
`else
                    exp_idx.push_back(i + 2 + LAT);
                    exp_dat.push_back(b);
`endif
                    idle_from = s + 9 * B + 1;
                end
            end
        end
    endtask

    task automatic compare_events(input string tag);
        check($sformatf("%s rcv count", tag), rcv_idx.size(), exp_idx.size());
        for (int k = 0; k < rcv_idx.size() && k < exp_idx.size(); k++) begin
            check($sformatf("%s rcv%0d cycle", tag, k), rcv_idx[k], exp_idx[k]);
            check($sformatf("%s rcv%0d data", tag, k), int'(rcv_dat[k]), int'(exp_dat[k]));
            check($sformatf("%s rcv%0d busy", tag, k), int'(busy_log[rcv_idx[k]]), 0);
        end
`ifdef UART_RX_FERR_EN
        check($sformatf("%s ferr count", tag), ferr_idx.size(), exp_ferr.size());
        for (int k = 0; k < ferr_idx.size() && k < exp_ferr.size(); k++)
            check($sformatf("%s ferr%0d cycle", tag, k), ferr_idx[k], exp_ferr[k]);
`endif
    endtask

    initial begin
        int         fidx;
        int         ones;
        int         rst_at;
        int         c3_idx;
        logic [7:0] rb;

        repeat (3) @(negedge clk);
        check("reset data", int'(data), 0);
        check("reset rcv", int'(rcv), 0);
        check("reset busy", int'(busy), 0);
`ifdef UART_RX_FERR_EN
        check("reset ferr", int'(ferr), 0);
`endif
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        vt[0] = '{0,  0, 8'h00, 8'h00, 1'b1, 0, 8'h00};
        vt[1] = '{0,  1, 8'h55, 8'h00, 1'b1, 1, 8'h55};
        vt[2] = '{0,  2, 8'hA5, 8'h3C, 1'b1, 2, 8'h3C};
        vt[3] = '{20, 1, 8'h0F, 8'h00, 1'b1, 1, 8'h0F};
`ifdef UART_RX_FERR_EN
        vt[4] = '{0,  1, 8'hF0, 8'h00, 1'b0, 0, 8'h0F};
`else
        vt[4] = '{0,  1, 8'hF0, 8'h00, 1'b0, 1, 8'hF0};
`endif

        for (int v = 0; v < 5; v++) begin
            wave.delete();
            add_level(1'b1, 10);
            if (vt[v].glitch > 0) begin
                add_level(1'b0, vt[v].glitch);
                add_level(1'b1, 100);
            end
            fidx = wave.size();
            if (vt[v].nfr == 0) add_level(1'b1, 500);
            if (vt[v].nfr >= 1) add_frame(vt[v].b0, vt[v].stop0);
            if (vt[v].nfr == 2) add_frame(vt[v].b1, 1'b1);
            add_level(1'b1, LAT + 10);
            play(-1);
            model();
            compare_events($sformatf("vec%0d", v));
            check($sformatf("vec%0d rcv pulses", v), rcv_idx.size(), vt[v].exp_n);
            check($sformatf("vec%0d final data", v), int'(data), int'(vt[v].exp_data));
            if (vt[v].nfr == 0) begin
                ones = 0;
                foreach (busy_log[i]) ones += int'(busy_log[i]);
                check("idle busy cycles", ones, 0);
            end
            if (vt[v].nfr >= 1 && vt[v].exp_n >= 1 && rcv_idx.size() >= 1)
                check($sformatf("vec%0d latency", v), rcv_idx[0] - (fidx + 2), 989);
            if (vt[v].nfr == 2 && rcv_idx.size() == 2)
                check("back-to-back spacing", rcv_idx[1] - rcv_idx[0], 1040);
            if (vt[v].glitch > 0) begin
                check("glitch busy at D+52", int'(busy_log[10 + 2 + 52]), 1);
                check("glitch busy at D+53", int'(busy_log[10 + 2 + 53]), 0);
            end
`ifdef UART_RX_FERR_EN
            if (vt[v].stop0 == 1'b0) check("ferr pulses", ferr_idx.size(), 1);
`endif
        end

        // Reset during data bit 4 of 0xF3, then a clean 0xC3 frame.
        wave.delete();
        add_level(1'b1, 10);
        add_frame(8'hF3, 1'b1);
        add_level(1'b1, 200);
        c3_idx = wave.size();
        add_frame(8'hC3, 1'b1);
        add_level(1'b1, LAT + 10);
        rst_at = 10 + 5 * B + H;
        play(rst_at);
        check("rst busy before", int'(busy_log[rst_at]), 1);
        check("rst busy after", int'(busy_log[rst_at + 1]), 0);
        check("rst rcv pulses", rcv_idx.size(), 1);
        if (rcv_idx.size() >= 1) begin
            check("rst C3 cycle", rcv_idx[0], c3_idx + 2 + LAT);
            check("rst C3 data", int'(rcv_dat[0]), 8'hC3);
        end
        check("rst final data", int'(data), 8'hC3);

        // Randomized traffic: frames, glitches, bad stops and varied gaps.
        for (int r = 0; r < 4; r++) begin
            wave.delete();
            add_level(1'b1, 10);
            for (int seg = 0; seg < 5; seg++) begin
                if ($urandom_range(0, 4) == 0) begin
                    add_level(1'b0, $urandom_range(1, 60));
                    add_level(1'b1, $urandom_range(1, 80));
                end else begin
                    rb = 8'($urandom);
                    add_frame(rb, ($urandom_range(0, 3) != 0));
                end
                add_level(1'b1, $urandom_range(0, 150));
            end
            add_level(1'b1, LAT + 10);
            play(-1);
            model();
            compare_events($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver, 8N1, LSB first, for the 12 MHz UpDuino designs.
- Counterpart of the existing uart_tx. Oversamples the asynchronous rx line, centres on each bit and delivers each received byte on a parallel bus with a one-cycle strobe.
- Sits between the board RX pin and the ADC interface command logic.

Parameters:
- BAUDRATE, default `B115200 (104 from baudgen.vh): clk cycles per bit period. Minimum 4.

Ports:
- clk  input  1  system clock, 12 MHz
- rstn  input  1  synchronous, active-low reset
- rx  input  1  asynchronous serial input; idles high
- data  output  8  last received byte; registered; held until the next good frame
- rcv  output  1  one-cycle strobe: data has just been updated
- busy  output  1  high while a frame is being received (states START..STOP)
- ferr  output  1  only when UART_RX_FERR_EN is defined: one-cycle framing-error strobe

Behaviour:
- Reset values (rstn=0 at a clk edge): data=8'h00, rcv=0, busy=0, ferr=0, state=IDLE, counters=0, synchroniser flops=1.
- Reset mid-frame: abandons the frame with no rcv strobe. Reception restarts only on a new falling edge after rstn=1.
- Input conditioning: rx passes through a 2-flop synchroniser (rx_s). The start edge is detected as rx_s falling (previous=1, current=0).
- Baud tick generator (sub-module):
  - Enabled by the FSM.
  - First tick comes BAUDRATE/2 (integer division) cycles after enable, then one every BAUDRATE cycles.
  - Disabling clears its counter.
  - Counter width is $clog2(BAUDRATE).
- Sample points: ticks at T = D + BAUDRATE/2 + k*BAUDRATE, where D is the edge-detect cycle.
  - k=0: start bit
  - k=1..8: data bits 0..7
  - k=9: stop bit
- FSM states:
  - IDLE: busy=0, tick gen disabled. On a falling edge, go to START.
  - START: wait for tick. On tick, rx_s=0 → DATA with bit counter cleared. rx_s=1 → false start (glitch), back to IDLE with no strobe.
  - DATA: on each tick, shift rx_s into the MSB of an 8-bit shift register (so it ends LSB-first correct) and increment the 3-bit counter. On the tick that captures bit 7 (counter wraps 7→0), go to STOP.
  - STOP: on tick, rx_s=1 → data <= shift register, rcv=1 for the next single cycle, go to IDLE. rx_s=0 → see Optional Feature.
- Latency: rcv is high on cycle D + BAUDRATE/2 + 9*BAUDRATE + 1 (989 cycles after D at 104).
- Back-to-back frames: IDLE is re-entered half a stop bit early, so a start edge arriving in the second half of the stop bit is accepted. A falling edge during START/DATA/STOP is ignored.
- rcv and data update in the same cycle. rcv is never high for two consecutive cycles.
- rx stuck low (break): at most one frame is processed. A new frame needs a rising then falling edge.

Optional Feature:
- Macro: UART_RX_FERR_EN.
- Defined:
  - The ferr port exists.
  - A stop sample of 0 pulses ferr for one cycle, leaves data unchanged, does not pulse rcv, and returns to IDLE.
- Undefined:
  - No ferr port.
  - A bad stop bit is not checked: data updates and rcv pulses as for a good frame.

Decomposition:
- baudgen.vh (shared header): B-rate constants, reused unchanged; add no new rates.
- uart_pkg.vh (shared header): FSM state localparams IDLE=0, START=1, DATA=2, STOP=3 (2 bits).
- Sub-module baudgen_rx (clk, rstn, clk_ena, clk_out): the half-period-first tick generator above.

Test Plan:
- BAUDRATE=104, idle rx=1 for 500 cycles → rcv never high, busy=0, data=00.
- Send 0x55 (start, 1010 1010 LSB-first, stop) → one rcv pulse exactly 989 cycles after the synced falling edge, data=0x55, busy drops the same cycle.
- Send 0xA5 then 0x3C with no idle gap → two rcv pulses 1040 cycles apart, data=0xA5 then 0x3C.
- Glitch: rx low for 20 cycles, then high → no rcv, state back to IDLE at D+53; a following 0x0F frame is received correctly.
- Send 0xF0 with stop bit 0:
  - macro off → rcv pulse, data=0xF0.
  - macro on → ferr pulse, no rcv, data keeps its previous value.
- Assert rstn=0 for 1 cycle during data bit 4 → rcv stays 0, busy=0 next cycle; a later 0xC3 frame is received as 0xC3.
